// File: rtl/count_seq_monitor_pkg.sv
// Shared types and helpers for the count sequence monitor.
// Optional glitch filter selected by COUNT_SEQ_MONITOR_GLITCH_FILTER_EN (see count_sampler).
package count_seq_monitor_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    CLS_STEP = 2'd0,
    CLS_WRAP = 2'd1,
    CLS_HOLD = 2'd2,
    CLS_JUMP = 2'd3
  } cls_e;

  // Bits needed to hold 0..hold_max, i.e. clog2(hold_max+1), never less than 1.
  function automatic int hold_cnt_w(input int hold_max);
    int w;
    w = 0;
    while ((1 << w) < (hold_max + 1)) begin
      w = w + 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/count_seq_monitor_sampler.sv
// Input register for the monitored count; with COUNT_SEQ_MONITOR_GLITCH_FILTER_EN defined a
// second register only lets a value through once two consecutive raw samples agree.
module count_sampler
  import count_seq_monitor_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] sample_o,
  output logic             sample_vld_o
);

  logic [CNT_W-1:0] raw0_q;
  logic             vld0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw0_q <= '0;
      vld0_q <= 1'b0;
    end else begin
      raw0_q <= cnt_i;
      vld0_q <= 1'b1;
    end
  end

`ifdef COUNT_SEQ_MONITOR_GLITCH_FILTER_EN
  logic [CNT_W-1:0] raw1_q;
  logic             vld1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw1_q <= '0;
      vld1_q <= 1'b0;
    end else begin
      raw1_q <= raw0_q;
      vld1_q <= vld0_q;
    end
  end

  // A ripple transient never survives two samples, so disagreeing pairs are simply dropped.
  assign sample_o     = raw1_q;
  assign sample_vld_o = vld1_q && (raw0_q == raw1_q);
`else
  assign sample_o     = raw0_q;
  assign sample_vld_o = vld0_q;
`endif

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors a free-running count: classifies each sample as step/wrap/hold/jump, counts wraps,
// flags stalls and latches a sticky error. Build option: COUNT_SEQ_MONITOR_GLITCH_FILTER_EN.
module count_seq_monitor
  import count_seq_monitor_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int WRAP_W   = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_rst,
  input  logic              err_clr,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              stall,
  output logic              err,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  last_cnt
);

  localparam int                HOLD_W   = hold_cnt_w(HOLD_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  logic [CNT_W-1:0] smp;
  logic             smp_vld;

  count_sampler #(
    .CNT_W (CNT_W)
  ) u_sampler (
    .clk          (clk),
    .rst_n        (reset),
    .cnt_i        (cnt_in),
    .sample_o     (smp),
    .sample_vld_o (smp_vld)
  );

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;

  cls_e              cls;
  logic [HOLD_W-1:0] hold_inc;
  logic [WRAP_W-1:0] wrap_inc;

  // Wrap is recognised explicitly from the max value rather than by letting p+1 overflow.
  function automatic cls_e classify(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] s);
    logic [CNT_W-1:0] p_inc;
    cls_e             c;
    p_inc = p + 1'b1;
    if ((p == CNT_MAX) && (s == '0)) begin
      c = CLS_WRAP;
    end else if ((p != CNT_MAX) && (s == p_inc)) begin
      c = CLS_STEP;
    end else if (s == p) begin
      c = CLS_HOLD;
    end else begin
      c = CLS_JUMP;
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      prev_q     <= '0;
      hold_q     <= '0;
      wrap_cnt_q <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      hold_q     <= hold_d;
      wrap_cnt_q <= wrap_cnt_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    hold_d     = hold_q;
    wrap_cnt_d = wrap_cnt_q;
    stall_d    = stall_q;
    err_d      = err_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    cls        = classify(prev_q, smp);
    hold_inc   = (hold_q >= HOLD_LIM) ? HOLD_LIM : hold_q + 1'b1;
    wrap_inc   = (wrap_cnt_q == WRAP_MAX) ? wrap_cnt_q : wrap_cnt_q + 1'b1;

    if (err_clr && (state_q == ST_ERR)) begin
      err_d   = 1'b0;
      state_d = ST_SYNC;
    end else if (cnt_rst && (state_q != ST_ERR)) begin
      // Counter restarting: next sample (normally 0) is re-acquired instead of judged.
      state_d = ST_SYNC;
      hold_d  = '0;
      stall_d = 1'b0;
    end else if (smp_vld) begin
      unique case (state_q)
        ST_SYNC: begin
          prev_d  = smp;
          hold_d  = '0;
          stall_d = 1'b0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          unique case (cls)
            CLS_STEP: begin
              step_d  = 1'b1;
              prev_d  = smp;
              hold_d  = '0;
              stall_d = 1'b0;
            end
            CLS_WRAP: begin
              step_d     = 1'b1;
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_inc;
              prev_d     = smp;
              hold_d     = '0;
              stall_d    = 1'b0;
            end
            CLS_HOLD: begin
              hold_d  = hold_inc;
              stall_d = (hold_inc == HOLD_LIM);
            end
            default: begin
              err_d   = 1'b1;
              prev_d  = smp;
              state_d = ST_ERR;
            end
          endcase
        end
        ST_ERR: begin
          prev_d = smp;
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign stall      = stall_q;
  assign err        = err_q;
  assign state      = state_q;
  assign last_cnt   = prev_q;

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the 4-bit ripple counter.
- Samples the counter output q in the clk domain and classifies each new sample as step, wrap (max->0), hold or illegal jump.
- Counts wrap-arounds, flags stalled counting, and latches a sticky error on any out-of-sequence value.
- Serves as an on-chip self-check of the counter and as a wrap-tick source for later stages.

Parameters:
- CNT_W, 4: width of the monitored count.
- WRAP_W, 8: width of the wrap-around counter.
- HOLD_MAX, 15: consecutive unchanged samples before stall asserts; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cnt_in  in  CNT_W  counter output q.
- cnt_rst  in  1  counter's own active-high reset, sampled synchronously; forces resync.
- err_clr  in  1  clears sticky error, synchronous, active-high.
- step_pulse  out  1  one-cycle pulse per legal increment, wrap included.
- wrap_pulse  out  1  one-cycle pulse per max->0 transition.
- wrap_cnt  out  WRAP_W  number of wraps, saturating.
- stall  out  1  level; count unchanged for HOLD_MAX or more samples.
- err  out  1  sticky illegal-transition flag.
- state  out  2  FSM state: SYNC=0, TRACK=1, ERR=2.
- last_cnt  out  CNT_W  last accepted count value.

Behaviour:
- Reset (reset=0, async) forces every output to 0, state=SYNC, and the internal sample, prev and hold counter to 0.
- Pipeline: cnt_in is registered into s_cnt at posedge k. Classification of s_cnt against prev updates all outputs at posedge k+1, i.e. 2-edge latency from cnt_in to outputs. All outputs are registered.
- Priority per edge: err_clr > cnt_rst > classification.
- SYNC:
  - Next sample loads prev and last_cnt.
  - hold counter cleared, no pulses.
  - Go to TRACK.
- TRACK, with p=prev and s=s_cnt:
  - Step: s==p+1 and p!=2^CNT_W-1. step_pulse=1, prev<=s, hold counter and stall cleared.
  - Wrap: p==2^CNT_W-1 and s==0. step_pulse=1, wrap_pulse=1, wrap_cnt+=1 saturating at all-ones (no rollover), hold counter and stall cleared.
  - Hold: s==p. hold counter+=1, saturating at HOLD_MAX. stall=1 once the counter reaches HOLD_MAX and stays 1 until the next step or wrap.
  - Jump: any other value. err=1, go to ERR, prev<=s, no pulses.
- ERR:
  - err stays 1. prev and last_cnt keep following s, with no pulses or counting.
  - err_clr=1: err<=0, go to SYNC.
  - cnt_rst has no effect in ERR.
- cnt_rst=1 in SYNC or TRACK:
  - Go to SYNC, clear hold counter and stall.
  - wrap_cnt and err are kept.
  - A 0 sample after cnt_rst is never a jump.
- err_clr outside ERR: no effect.
- Reset mid-pulse: pulse is cut immediately (async). Monitoring restarts in SYNC.
- Arithmetic: p+1 computed in CNT_W bits. Wrap is detected explicitly, not via overflow.

Optional Feature:
- Macro: COUNT_SEQ_MONITOR_GLITCH_FILTER_EN.
- Defined:
  - A second sample register is added.
  - A value is presented for classification only when two consecutive raw samples are equal, which adds 1 cycle of latency (3 edges total).
  - Unequal consecutive samples are ignored; they are neither a hold nor a jump, and the hold counter does not change.
  - The counter must hold each value for 2 or more clk cycles.
- Undefined: direct classification as specified above, with ripple transients visible as jumps.

Decomposition:
- Shared package holds:
  - State encodings SYNC/TRACK/ERR, 2-bit.
  - Classification enum STEP/WRAP/HOLD/JUMP.
  - Hold-counter width function clog2(HOLD_MAX+1).
- One sub-module: count_sampler. It holds the input register plus the optional glitch filter and outputs sample and sample_vld.
- FSM, classification and counters live in the top module.

Test Plan:
- Reset, then cnt_in 0,1,2..15,0,1 changing every clk -> 16 step_pulses over 0..15, 1 wrap_pulse at the 15->0 transition, wrap_cnt=1, err=0, state=TRACK.
- cnt_in held at 5 for 20 samples -> stall asserts after 15 held samples; next value 6 -> stall=0 and step_pulse=1.
- Sequence 3,4,9 -> err=1, state=ERR. Then 10,11 -> no pulses. err_clr=1 -> err=0, state=SYNC, then TRACK on the next sample.
- cnt_rst=1 with cnt_in going 7->0 -> no err, state goes through SYNC, wrap_cnt unchanged.
- 300 full 0..15 cycles with WRAP_W=8 -> wrap_cnt saturates at 255.
- With the macro defined: cnt_in 2,2,X(one-cycle glitch 7),3,3 -> single step_pulse 2->3, err=0. With the macro undefined, the same stimulus gives err=1.
